// File: rtl/eviction_write_buffer_pkg.sv
// eviction_write_buffer_pkg: LC-3b word/block/tag types and the write-buffer FSM state encoding.
package eviction_write_buffer_pkg;
  localparam int LC3B_OFFSET_BITS = 4;
  typedef logic [15:0] lc3b_word;
  typedef logic [127:0] lc3b_block;
  typedef logic [15-LC3B_OFFSET_BITS:0] lc3b_tag;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, RESP} ewb_state_t;
  function automatic lc3b_tag addr_tag(lc3b_word a);
    return a[15:LC3B_OFFSET_BITS];
  endfunction
  function automatic lc3b_word tag_addr(lc3b_tag t);
    return {t, {LC3B_OFFSET_BITS{1'b0}}};
  endfunction
endpackage

// File: rtl/eviction_write_buffer_if.sv
// eviction_write_buffer_if: cache-side and memory-side signals of the eviction write buffer.
interface eviction_write_buffer_if;
  import eviction_write_buffer_pkg::*;
  logic      cache_read;
  logic      cache_write;
  lc3b_word  cache_address;
  lc3b_block cache_wdata;
  lc3b_block cache_rdata;
  logic      cache_resp;
  logic      mem_read;
  logic      mem_write;
  lc3b_word  mem_address;
  lc3b_block mem_wdata;
  lc3b_block mem_rdata;
  logic      mem_resp;
  modport slave (
    input  cache_read, cache_write, cache_address, cache_wdata, mem_rdata, mem_resp,
    output cache_rdata, cache_resp, mem_read, mem_write, mem_address, mem_wdata
  );
  modport master (
    output cache_read, cache_write, cache_address, cache_wdata, mem_rdata, mem_resp,
    input  cache_rdata, cache_resp, mem_read, mem_write, mem_address, mem_wdata
  );
endinterface

// File: rtl/eviction_write_buffer_entry.sv
// ewb_entry: the single buffered dirty block (valid, tag, data) with a combinational tag hit.
module ewb_entry
  import eviction_write_buffer_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      load_i,
  input  logic      clear_i,
  input  lc3b_tag   tag_i,
  input  lc3b_block wdata_i,
  output logic      valid_o,
  output lc3b_tag   tag_o,
  output lc3b_block data_o,
  output logic      hit_o
);
  logic      valid_q;
  lc3b_tag   tag_q;
  lc3b_block data_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      tag_q   <= tag_i;
      data_q  <= wdata_i;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end
  end
  assign valid_o = valid_q;
  assign tag_o   = tag_q;
  assign data_o  = data_q;
  assign hit_o   = valid_q && (tag_q == tag_i);
endmodule

// File: rtl/eviction_write_buffer.sv
// eviction_write_buffer: single-entry writeback buffer; reads go first, the block drains when idle.
// Define EWB_FORWARD_EN to serve reads that hit the buffered block directly from the buffer.
module eviction_write_buffer
  import eviction_write_buffer_pkg::*;
(
  input logic clk,
  input logic rst_n,
  eviction_write_buffer_if.slave bus
);
  ewb_state_t state_q, state_d;
  lc3b_tag    req_tag_q, req_tag_d;
  lc3b_block  rdata_q, rdata_d;
  logic       load, clear, hit, valid;
  lc3b_tag    tag, cache_tag;
  lc3b_block  data;
  assign cache_tag = addr_tag(bus.cache_address);
  ewb_entry u_entry (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load),
    .clear_i (clear),
    .tag_i   (cache_tag),
    .wdata_i (bus.cache_wdata),
    .valid_o (valid),
    .tag_o   (tag),
    .data_o  (data),
    .hit_o   (hit)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_tag_q <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      req_tag_q <= req_tag_d;
      rdata_q   <= rdata_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    req_tag_d = req_tag_q;
    rdata_d   = rdata_q;
    load      = 1'b0;
    clear     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cache_read && hit) begin
`ifdef EWB_FORWARD_EN
          rdata_d = data;
          state_d = RESP;
`else
          state_d = DRAIN;
`endif
        end else if (bus.cache_read) begin
          req_tag_d = cache_tag;
          state_d   = READ;
        end else if (bus.cache_write && !valid) begin
          load    = 1'b1;
          state_d = RESP;
        end else if (valid) begin
          // a pending write into a full buffer, or no request at all, both drain first
          state_d = DRAIN;
        end
      end
      READ: begin
        if (bus.mem_resp) begin
          rdata_d = bus.mem_rdata;
          state_d = RESP;
        end
      end
      DRAIN: begin
        if (bus.mem_resp) begin
          clear   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.cache_resp  = state_q == RESP;
  assign bus.cache_rdata = rdata_q;
  assign bus.mem_read    = state_q == READ;
  assign bus.mem_write   = state_q == DRAIN;
  assign bus.mem_address = (state_q == READ)  ? tag_addr(req_tag_q) :
                           (state_q == DRAIN) ? tag_addr(tag) : '0;
  assign bus.mem_wdata   = (state_q == DRAIN) ? data : '0;
endmodule
